// File: rtl/shift_seq.sv
// Multi-cycle rotate/shift sequencer: applies one binary stage (1, 2, 4, 8, ...)
// per cycle to a working register, under valid/ready handshakes on both sides.
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNTW-1:0]  in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int KW = (CNTW > 1) ? $clog2(CNTW) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [KW-1:0]     k, k_nx;
  logic [CNTW-1:0]   cnt, cnt_nx;
  logic [1:0]        op, op_nx;
  logic [WIDTH-1:0]  work, work_nx;

  // One stage of the datapath: apply op by 2**idx; rotates use a doubled word.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       o,
                                                   input logic [KW-1:0]    idx);
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rl;
    logic [2*WIDTH-1:0] rr;
    int unsigned        amt;
    logic [WIDTH-1:0]   r;
    amt = 32'd1 << idx;
    dbl = {d, d};
    rl  = dbl << amt;
    rr  = dbl >> amt;
    case (o)
      2'b00:   r = rl[2*WIDTH-1:WIDTH];
      2'b01:   r = d << amt;
      2'b10:   r = rr[WIDTH-1:0];
      2'b11:   r = d >> amt;
      default: r = d;
    endcase
    return r;
  endfunction

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;

  // Next-state and datapath update.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    cnt_nx   = cnt;
    op_nx    = op;
    work_nx  = work;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_nx  = in_data;
          cnt_nx   = in_cnt;
          op_nx    = in_op;
          k_nx     = KW'(0);
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        if (cnt[k]) begin
          work_nx = stage_shift(work, op, k);
        end else begin
          work_nx = work;
        end
        if (k == KW'(CNTW - 1)) begin
          k_nx     = KW'(0);
          state_nx = DONE;
        end else begin
          k_nx     = k + KW'(1);
          state_nx = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= KW'(0);
      cnt   <= '0;
      op    <= 2'b00;
      work  <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      cnt   <= cnt_nx;
      op    <= op_nx;
      work  <= work_nx;
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed and randomized checks of shift_seq against a bit-at-a-time reference model.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  shift_seq #(.WIDTH(16), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: move one bit position per step, cnt steps.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] op, input int cnt);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < cnt; i++) begin
      case (op)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[0], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, measure latency, check result, release.
  task automatic run_txn(input string tag, input logic [15:0] d, input logic [1:0] op, input logic [3:0] cnt);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_data = d; in_op = op; in_cnt = cnt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) break;
      @(posedge clk); #1;
      lat = c;
    end
    chk({tag, "_latency"}, lat, 32'd4);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, model(d, op, int'(cnt))});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, busy, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] held;
    logic [15:0] q[$];
    int last;
    int got;

    rst = 1'b1; in_valid = 1'b0; in_data = 16'd0; in_cnt = 4'd0; in_op = 2'b00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd1);

    run_txn("rol_8001_1", 16'h8001, 2'b00, 4'd1);
    chk("rol_const", {16'd0, model(16'h8001, 2'b00, 1)}, 32'h0003);
    run_txn("sll_ffff_15", 16'hFFFF, 2'b01, 4'd15);
    run_txn("srl_8000_15", 16'h8000, 2'b11, 4'd15);
    run_txn("ror_1234_4", 16'h1234, 2'b10, 4'd4);
    for (int o = 0; o < 4; o++) run_txn("cnt0", 16'hA5C3, 2'(o), 4'd0);

    // DONE held with out_ready low while a new request is offered.
    @(negedge clk);
    in_data = 16'h00F0; in_op = 2'b00; in_cnt = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 16'hFFFF; in_cnt = 4'd7;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    held = out_data;
    chk("hold_data0", {16'd0, held}, 32'h0780);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_data", {16'd0, out_data}, {16'd0, held});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release", {30'd0, busy, out_valid}, 32'd0);

    // Reset during SHIFT stage 2 abandons the transaction.
    @(negedge clk);
    in_data = 16'h1111; in_op = 2'b01; in_cnt = 4'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_in_ready1", {31'd0, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_no_result", {31'd0, out_valid}, 32'd0);
    run_txn("after_rst", 16'hBEEF, 2'b10, 4'd9);

    // Back-to-back streaming: a result every 6 cycles.
    last = -1; got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("b2b_data", {16'd0, out_data}, (q.size() > 0) ? {16'd0, q[0]} : 32'hDEAD);
        if (q.size() > 0) void'(q.pop_front());
        if (last >= 0) chk("b2b_spacing", cyc - last, 32'd6);
        last = cyc;
        got++;
      end
      if (in_ready) begin
        in_data = 16'($urandom); in_op = 2'($urandom_range(3)); in_cnt = 4'($urandom_range(15));
        in_valid = 1'b1;
        q.push_back(model(in_data, in_op, int'(in_cnt)));
      end
    end
    chk("b2b_count", got, 32'd6);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (8) @(posedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Exhaustive op x cnt with random operands.
    for (int o = 0; o < 4; o++)
      for (int c = 0; c < 16; c++)
        run_txn("sweep", 16'($urandom), 2'(o), 4'(c));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
